execute_stage: RTL and testbench

- Third stage of the 5-stage RISC-V pipeline; sits directly downstream of decode.
- Consumes decode's registered outputs, computes the ALU result, and resolves conditional branches, JAL and JALR.
- Drives the redirect (pc_sel/jmp_addr) back to fetch.
- Registers results into the EX/MEM pipeline register, with stall-hold and flush-bubble behaviour.

---
 rtl/execute_stage.sv | 173 +++++++++++++++++
 tb/tb_execute_stage.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/execute_stage.sv
// RISC-V execute stage: ALU, branch/jump resolution with same-cycle redirect to fetch,
// and the EX/MEM pipeline register with stall-hold and flush-bubble behaviour.
module execute_stage #(
  parameter int XLEN  = 32,
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             flush,
  input  logic [XLEN-1:0]  i_pc,
  input  logic [XLEN-1:0]  i_pc4,
  input  logic [XLEN-1:0]  i_reg1,
  input  logic [XLEN-1:0]  i_reg2,
  input  logic [XLEN-1:0]  i_imm,
  input  logic             i_reg1_sel,
  input  logic             i_reg2_sel,
  input  logic [2:0]       i_func3,
  input  logic             i_instr30,
  input  logic [1:0]       i_alu_op,
  input  logic [1:0]       i_branch_op,
  input  logic             i_mem_w_en,
  input  logic [IDX_W-1:0] i_w_idx,
  input  logic [1:0]       i_wb_sel,
  input  logic             i_wb_en,
  output logic             o_pc_sel,
  output logic [XLEN-1:0]  o_jmp_addr,
  output logic [XLEN-1:0]  o_alu_res,
  output logic [XLEN-1:0]  o_store_data,
  output logic [2:0]       o_func3,
  output logic [XLEN-1:0]  o_pc4,
  output logic             o_mem_w_en,
  output logic [IDX_W-1:0] o_w_idx,
  output logic [1:0]       o_wb_sel,
  output logic             o_wb_en
);

  function automatic logic [XLEN-1:0] alu_calc(
    input logic [1:0]      op,
    input logic [2:0]      f3,
    input logic            i30,
    input logic [XLEN-1:0] a,
    input logic [XLEN-1:0] b
  );
    logic [4:0]             sh;
    logic signed [XLEN-1:0] sa;
    logic [XLEN-1:0]        res;
    sh  = b[4:0];
    sa  = $signed(a);
    res = a + b;
    case (op)
      2'b00: res = a + b;
      2'b11: res = b;
      default: begin
        // Immediate forms never subtract; only R-type honours instr30 for func3=000.
        case (f3)
          3'd0: res = (op == 2'b01 && i30) ? a - b : a + b;
          3'd1: res = a << sh;
          3'd2: res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
          3'd3: res = {{(XLEN-1){1'b0}}, (a < b)};
          3'd4: res = a ^ b;
          3'd5: begin
            if (i30) res = sa >>> sh;
            else     res = a >> sh;
          end
          3'd6: res = a | b;
          3'd7: res = a & b;
        endcase
      end
    endcase
    return res;
  endfunction

  function automatic logic branch_cond(
    input logic [2:0]      f3,
    input logic [XLEN-1:0] r1,
    input logic [XLEN-1:0] r2
  );
    logic c;
    case (f3)
      3'd0:    c = (r1 == r2);
      3'd1:    c = (r1 != r2);
      3'd4:    c = ($signed(r1) <  $signed(r2));
      3'd5:    c = ($signed(r1) >= $signed(r2));
      3'd6:    c = (r1 <  r2);
      3'd7:    c = (r1 >= r2);
      default: c = 1'b0;
    endcase
    return c;
  endfunction

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] reg_target;
  logic            taken;
  logic [XLEN-1:0] target;

  assign op_a       = i_reg1_sel ? i_pc  : i_reg1;
  assign op_b       = i_reg2_sel ? i_imm : i_reg2;
  assign alu_res    = alu_calc(i_alu_op, i_func3, i_instr30, op_a, op_b);
  assign pc_target  = i_pc + i_imm;
  assign reg_target = i_reg1 + i_imm;

  always_comb begin
    taken  = 1'b0;
    target = '0;
    case (i_branch_op)
      2'b01: begin
        taken  = branch_cond(i_func3, i_reg1, i_reg2);
        target = pc_target;
      end
      2'b10: begin
        taken  = 1'b1;
        target = pc_target;
      end
      2'b11: begin
        taken  = 1'b1;
        target = {reg_target[XLEN-1:1], 1'b0};
      end
      default: begin
        taken  = 1'b0;
        target = '0;
      end
    endcase
  end

  assign o_pc_sel   = taken & ~stall & ~rst;
  assign o_jmp_addr = taken ? target : '0;

  // EX/MEM boundary
  logic [XLEN-1:0]  alu_res_p1;
  logic [XLEN-1:0]  store_data_p1;
  logic [2:0]       func3_p1;
  logic [XLEN-1:0]  pc4_p1;
  logic             mem_w_en_p1;
  logic [IDX_W-1:0] w_idx_p1;
  logic [1:0]       wb_sel_p1;
  logic             wb_en_p1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      alu_res_p1    <= '0;
      store_data_p1 <= '0;
      func3_p1      <= '0;
      pc4_p1        <= '0;
      mem_w_en_p1   <= 1'b0;
      w_idx_p1      <= '0;
      wb_sel_p1     <= '0;
      wb_en_p1      <= 1'b0;
    end else if (!stall) begin
      alu_res_p1    <= alu_res;
      store_data_p1 <= i_reg2;
      func3_p1      <= i_func3;
      pc4_p1        <= i_pc4;
      mem_w_en_p1   <= i_mem_w_en;
      w_idx_p1      <= i_w_idx;
      wb_sel_p1     <= i_wb_sel;
      wb_en_p1      <= i_wb_en;
    end
  end

  assign o_alu_res    = alu_res_p1;
  assign o_store_data = store_data_p1;
  assign o_func3      = func3_p1;
  assign o_pc4        = pc4_p1;
  assign o_mem_w_en   = mem_w_en_p1;
  assign o_w_idx      = w_idx_p1;
  assign o_wb_sel     = wb_sel_p1;
  assign o_wb_en      = wb_en_p1;

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed literal cases plus randomized traffic against a reference model.
module tb_execute_stage;
  localparam int XLEN  = 32;
  localparam int IDX_W = 5;

  logic             clk = 1'b0;
  logic             rst, stall, flush;
  logic [XLEN-1:0]  i_pc, i_pc4, i_reg1, i_reg2, i_imm;
  logic             i_reg1_sel, i_reg2_sel, i_instr30, i_mem_w_en, i_wb_en;
  logic [2:0]       i_func3;
  logic [1:0]       i_alu_op, i_branch_op, i_wb_sel;
  logic [IDX_W-1:0] i_w_idx;
  logic             o_pc_sel, o_mem_w_en, o_wb_en;
  logic [XLEN-1:0]  o_jmp_addr, o_alu_res, o_store_data, o_pc4;
  logic [2:0]       o_func3;
  logic [IDX_W-1:0] o_w_idx;
  logic [1:0]       o_wb_sel;

  execute_stage #(.XLEN(XLEN), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .i_pc(i_pc), .i_pc4(i_pc4), .i_reg1(i_reg1), .i_reg2(i_reg2), .i_imm(i_imm),
    .i_reg1_sel(i_reg1_sel), .i_reg2_sel(i_reg2_sel), .i_func3(i_func3),
    .i_instr30(i_instr30), .i_alu_op(i_alu_op), .i_branch_op(i_branch_op),
    .i_mem_w_en(i_mem_w_en), .i_w_idx(i_w_idx), .i_wb_sel(i_wb_sel), .i_wb_en(i_wb_en),
    .o_pc_sel(o_pc_sel), .o_jmp_addr(o_jmp_addr), .o_alu_res(o_alu_res),
    .o_store_data(o_store_data), .o_func3(o_func3), .o_pc4(o_pc4),
    .o_mem_w_en(o_mem_w_en), .o_w_idx(o_w_idx), .o_wb_sel(o_wb_sel), .o_wb_en(o_wb_en)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Expected EX/MEM contents
  logic [XLEN-1:0]  e_alu, e_store, e_pc4;
  logic [2:0]       e_f3;
  logic             e_mw, e_wben;
  logic [IDX_W-1:0] e_widx;
  logic [1:0]       e_wbsel;

  task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [XLEN-1:0] ref_alu();
    logic [XLEN-1:0] a, b;
    int unsigned     s;
    logic            r_type;
    a = i_reg1_sel ? i_pc : i_reg1;
    b = i_reg2_sel ? i_imm : i_reg2;
    s = b % 32;
    r_type = (i_alu_op == 2'b01);
    if (i_alu_op == 2'b00) return a + b;
    if (i_alu_op == 2'b11) return b;
    case (i_func3)
      3'd0: return (r_type && i_instr30) ? a + (~b + 1) : a + b;
      3'd1: return a * (2 ** s);
      3'd2: return ($signed(a) < $signed(b)) ? 1 : 0;
      3'd3: return (a < b) ? 1 : 0;
      3'd4: return a ^ b;
      3'd5: begin
        if (i_instr30 && a[XLEN-1]) return ~((~a) / (2 ** s));
        return a / (2 ** s);
      end
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic ref_taken();
    longint s1, s2;
    s1 = $signed(i_reg1);
    s2 = $signed(i_reg2);
    if (i_branch_op == 2'b10 || i_branch_op == 2'b11) return 1'b1;
    if (i_branch_op == 2'b00) return 1'b0;
    case (i_func3)
      3'd0: return i_reg1 == i_reg2;
      3'd1: return i_reg1 != i_reg2;
      3'd4: return s1 < s2;
      3'd5: return s1 >= s2;
      3'd6: return i_reg1 < i_reg2;
      3'd7: return i_reg1 >= i_reg2;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] ref_target();
    if (!ref_taken()) return '0;
    if (i_branch_op == 2'b11) return (i_reg1 + i_imm) & ~32'd1;
    return i_pc + i_imm;
  endfunction

  task automatic clear_exp();
    e_alu = '0; e_store = '0; e_pc4 = '0; e_f3 = '0;
    e_mw = 1'b0; e_wben = 1'b0; e_widx = '0; e_wbsel = '0;
  endtask

  task automatic set_nop();
    stall = 0; flush = 0;
    i_pc = '0; i_pc4 = '0; i_reg1 = '0; i_reg2 = '0; i_imm = '0;
    i_reg1_sel = 0; i_reg2_sel = 0; i_func3 = '0; i_instr30 = 0;
    i_alu_op = '0; i_branch_op = '0; i_mem_w_en = 0; i_w_idx = '0;
    i_wb_sel = '0; i_wb_en = 0;
  endtask

  task automatic randomize_inputs();
    i_pc        = $urandom & 32'hFFFF_FFFC;
    i_pc4       = i_pc + 4;
    i_reg1      = $urandom;
    i_reg2      = ($urandom_range(0, 3) == 0) ? i_reg1 : $urandom;
    if ($urandom_range(0, 3) == 0) i_reg2 = $urandom_range(0, 40);
    i_imm       = ($urandom_range(0, 1) == 0) ? $urandom : 32'($signed(12'($urandom)));
    i_reg1_sel  = 1'($urandom);
    i_reg2_sel  = 1'($urandom);
    i_func3     = 3'($urandom);
    i_instr30   = 1'($urandom);
    i_alu_op    = 2'($urandom);
    i_branch_op = 2'($urandom);
    i_mem_w_en  = 1'($urandom);
    i_w_idx     = 5'($urandom);
    i_wb_sel    = 2'($urandom_range(0, 2));
    i_wb_en     = 1'($urandom);
  endtask

  // One clock: redirect checked mid-cycle, register contents checked just after the edge.
  task automatic cycle();
    logic [XLEN-1:0] nalu;
    @(negedge clk);
    chk("pc_sel", {31'd0, o_pc_sel}, {31'd0, ref_taken() & ~stall});
    chk("jmp_addr", o_jmp_addr, ref_target());
    nalu = ref_alu();
    if (flush) clear_exp();
    else if (!stall) begin
      e_alu = nalu; e_store = i_reg2; e_pc4 = i_pc4; e_f3 = i_func3;
      e_mw = i_mem_w_en; e_wben = i_wb_en; e_widx = i_w_idx; e_wbsel = i_wb_sel;
    end
    @(posedge clk);
    #1;
    chk("alu_res", o_alu_res, e_alu);
    chk("store_data", o_store_data, e_store);
    chk("pc4", o_pc4, e_pc4);
    chk("ctrl", {21'd0, o_func3, o_mem_w_en, o_w_idx, o_wb_sel, o_wb_en},
                {21'd0, e_f3, e_mw, e_widx, e_wbsel, e_wben});
  endtask

  initial begin
    set_nop();
    rst = 1;
    clear_exp();
    #2;
    chk("reset_regs", {o_alu_res ^ o_pc4 ^ o_store_data}, '0);
    chk("reset_ctrl", {21'd0, o_func3, o_mem_w_en, o_w_idx, o_wb_sel, o_wb_en}, '0);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // R-type SUB, SLT, SLTU, SRA
    set_nop(); i_reg1 = 5; i_reg2 = 7; i_alu_op = 2'b01; i_instr30 = 1; i_wb_en = 1;
    cycle(); chk("lit_sub", o_alu_res, 32'hFFFF_FFFE);
    i_reg1 = 32'hFFFF_FFFF; i_reg2 = 1; i_func3 = 3'd2; i_instr30 = 0;
    cycle(); chk("lit_slt", o_alu_res, 32'd1);
    i_func3 = 3'd3;
    cycle(); chk("lit_sltu", o_alu_res, 32'd0);
    i_reg1 = 32'h8000_0000; i_reg2 = 4; i_func3 = 3'd5; i_instr30 = 1;
    cycle(); chk("lit_sra", o_alu_res, 32'hF800_0000);

    // BEQ taken / not taken
    set_nop(); i_pc = 32'h100; i_imm = 32'h20; i_reg1 = 9; i_reg2 = 9; i_branch_op = 2'b01;
    #1;
    chk("lit_beq_sel", {31'd0, o_pc_sel}, 32'd1);
    chk("lit_beq_addr", o_jmp_addr, 32'h120);
    cycle();
    i_reg2 = 8; #1;
    chk("lit_beq_nt", {31'd0, o_pc_sel}, 32'd0);
    cycle();

    // JALR
    set_nop(); i_reg1 = 32'h203; i_imm = 4; i_branch_op = 2'b11; i_wb_sel = 2'b10;
    i_pc4 = 32'h44; i_wb_en = 1; #1;
    chk("lit_jalr_addr", o_jmp_addr, 32'h206);
    chk("lit_jalr_sel", {31'd0, o_pc_sel}, 32'd1);
    cycle();
    chk("lit_jalr_pc4", o_pc4, 32'h44);
    chk("lit_jalr_wben", {31'd0, o_wb_en}, 32'd1);

    // Stall hold
    set_nop(); i_reg1 = 8; i_reg2 = 8; i_wb_en = 1;
    cycle(); chk("lit_add", o_alu_res, 32'h10);
    for (int k = 0; k < 3; k++) begin
      randomize_inputs();
      stall = 1; i_branch_op = 2'b01; i_func3 = 3'd0; i_reg2 = i_reg1; #1;
      chk("lit_stall_sel", {31'd0, o_pc_sel}, 32'd0);
      cycle();
      chk("lit_stall_hold", o_alu_res, 32'h10);
    end

    // Flush, then flush+stall
    set_nop(); i_mem_w_en = 1; i_wb_en = 1; i_reg1 = 3; flush = 1;
    cycle();
    chk("lit_flush_mw", {31'd0, o_mem_w_en}, 32'd0);
    chk("lit_flush_wb", {31'd0, o_wb_en}, 32'd0);
    flush = 0; cycle();
    flush = 1; stall = 1; cycle();
    chk("lit_fs_alu", o_alu_res, 32'd0);
    chk("lit_fs_wb", {31'd0, o_wb_en}, 32'd0);

    // Asynchronous reset mid-cycle
    set_nop(); i_reg1 = 32'h55; i_wb_en = 1; i_mem_w_en = 1; i_w_idx = 5'd7;
    cycle();
    i_branch_op = 2'b10; i_imm = 32'h40;
    #2 rst = 1;
    #1;
    chk("lit_rst_alu", o_alu_res, 32'd0);
    chk("lit_rst_ctrl", {21'd0, o_func3, o_mem_w_en, o_w_idx, o_wb_sel, o_wb_en}, 32'd0);
    chk("lit_rst_sel", {31'd0, o_pc_sel}, 32'd0);
    clear_exp();
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      randomize_inputs();
      stall = ($urandom_range(0, 5) == 0);
      flush = ($urandom_range(0, 7) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
